// File: rtl/n163_audio_pkg.sv
// Shared types and default widths for the N163 audio output filter.
package n163_audio_pkg;

    localparam int IN_W_DEF   = 11;
    localparam int FRAC_W_DEF = 6;
    localparam int OUT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        UPDATE,
        SCALE
    } state_t;

    function automatic logic [2:0] gain_shift(input logic [1:0] g);
        logic [2:0] s;
        unique case (g)
            2'd0: s = 3'd5;
            2'd1: s = 3'd4;
            2'd2: s = 3'd3;
            2'd3: s = 3'd6;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/n163_audio_sat.sv
// Gain shift and positive saturation of the integer filter level.
module n163_audio_sat
    import n163_audio_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [IN_W-1:0]  i_level,
    input  logic [1:0]       i_gain_sel,
    output logic [OUT_W-1:0] o_audio
);

    localparam int SW = (IN_W + 6 > OUT_W) ? IN_W + 6 : OUT_W;
    localparam logic [OUT_W-1:0] MAX = {1'b0, {(OUT_W-1){1'b1}}};

    logic [SW-1:0] w_wide;
    logic [SW-1:0] w_max;

    assign w_wide  = SW'(i_level) << gain_shift(i_gain_sel);
    assign w_max   = SW'(MAX);
    assign o_audio = (w_wide > w_max) ? MAX : w_wide[OUT_W-1:0];

endmodule

// File: rtl/n163_audio_filter.sv
// One-pole low-pass filter for the N163 channel sum with a one-entry
// sample hold, gain select and saturated output.
module n163_audio_filter
    import n163_audio_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [IN_W-1:0]  sample_in,
    input  logic             sample_valid,
    input  logic [1:0]       shift_sel,
    input  logic [1:0]       gain_sel,
    input  logic             overrun_clr,
    output logic [OUT_W-1:0] audio_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int YW = IN_W + FRAC_W;
    localparam int DW = YW + 1;

    state_t r_state;
    state_t w_next;

    logic [IN_W-1:0]      r_x;
    logic [IN_W-1:0]      r_hold;
    logic                 r_hold_full;
    logic [YW-1:0]        r_y;
    logic signed [DW-1:0] r_diff;
    logic [OUT_W-1:0]     r_audio;
    logic                 r_out_valid;
    logic                 r_overrun;

    logic [YW-1:0]        w_x_ext;
    logic signed [DW-1:0] w_diff;
    logic [2:0]           w_k;
    logic signed [DW-1:0] w_step;
    logic signed [DW:0]   w_sum;
    logic [YW-1:0]        w_y_next;
    logic [OUT_W-1:0]     w_sat;

    logic w_take_hold;
    logic w_take_in;
    logic w_start;
    logic w_to_hold;
    logic w_ovr_set;

    assign w_x_ext = {r_x, {FRAC_W{1'b0}}};
    assign w_diff  = $signed({1'b0, w_x_ext}) - $signed({1'b0, r_y});
    assign w_k     = {1'b0, shift_sel} + 3'd1;
    assign w_step  = r_diff >>> w_k;
    assign w_sum   = $signed({2'b00, r_y}) + $signed({w_step[DW-1], w_step});

    // Clamp to the unsigned state range.
    always_comb begin
        w_y_next = w_sum[YW-1:0];
        if (w_sum[DW]) begin
            w_y_next = '0;
        end else if (w_sum[DW-1]) begin
            w_y_next = '1;
        end
    end

    n163_audio_sat #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .i_level    (w_y_next[YW-1:FRAC_W]),
        .i_gain_sel (gain_sel),
        .o_audio    (w_sat)
    );

    // A held sample is served whenever the engine is free to start.
    assign w_take_hold = r_hold_full && (r_state == IDLE || r_state == SCALE);
    assign w_take_in   = sample_valid && r_state == IDLE && !r_hold_full;
    assign w_start     = w_take_hold || w_take_in;
    assign w_to_hold   = sample_valid && !w_take_in;
    assign w_ovr_set   = sample_valid && r_hold_full && !w_take_hold;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:   w_next = w_start ? CALC : IDLE;
            CALC:   w_next = UPDATE;
            UPDATE: w_next = SCALE;
            SCALE:  w_next = w_start ? CALC : IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_y         <= '0;
            r_diff      <= '0;
            r_audio     <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (enable && w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
            if (!enable) begin
                r_state     <= IDLE;
                r_x         <= '0;
                r_hold_full <= 1'b0;
                r_y         <= '0;
                r_diff      <= '0;
                r_audio     <= '0;
                r_out_valid <= 1'b0;
            end else begin
                r_state     <= w_next;
                r_out_valid <= (r_state == UPDATE);
                if (w_start) begin
                    r_x <= w_take_hold ? r_hold : sample_in;
                end
                if (w_to_hold) begin
                    r_hold      <= sample_in;
                    r_hold_full <= 1'b1;
                end else if (w_take_hold) begin
                    r_hold_full <= 1'b0;
                end
                if (r_state == CALC) begin
                    r_diff <= w_diff;
                end
                if (r_state == UPDATE) begin
                    r_y     <= w_y_next;
                    r_audio <= w_sat;
                end
            end
        end
    end

    assign audio_out = r_audio;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != IDLE);
    assign overrun   = r_overrun;

endmodule
